// File: rtl/btb_update_ctrl_pkg.sv
// Shared BTB geometry, PC field positions, controller state encoding and
// helpers that build the masked single-slot write for a resolved branch.
package btb_update_ctrl_pkg;

  localparam int BTB_SETS       = 512;
  localparam int BTB_ADDR_WIDTH = 9;
  localparam int BTB_DATA_WIDTH = 129;
  localparam int BTB_SLOTS      = 4;
  localparam int BTB_VALID_BIT  = 128;

  localparam int PC_IDX_LSB  = 4;
  localparam int PC_IDX_MSB  = 12;
  localparam int PC_SLOT_LSB = 2;
  localparam int PC_SLOT_MSB = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } btb_state_e;

  // Valid bit plus the 32-bit field of the addressed slot.
  function automatic logic [BTB_DATA_WIDTH-1:0] slot_mask(input logic [1:0] slot);
    logic [BTB_DATA_WIDTH-1:0] m;
    m = '0;
    m[BTB_VALID_BIT] = 1'b1;
    m[{1'b0, slot, 5'd0} +: 32] = 32'hFFFF_FFFF;
    return m;
  endfunction

  function automatic logic [BTB_DATA_WIDTH-1:0] slot_data(input logic [1:0]  slot,
                                                          input logic [31:0] target);
    logic [BTB_DATA_WIDTH-1:0] d;
    d = '0;
    d[BTB_VALID_BIT] = 1'b1;
    d[{1'b0, slot, 5'd0} +: 32] = target;
    return d;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous update queue; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 43
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer next-state: clear has priority over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + (PW+1)'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !clr_i) begin
      mem_q[wr_ptr_q[PW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: invalidation sweep after reset/flush, then one
// masked single-slot write per queued taken-branch update.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETS       = BTB_SETS,
  parameter int ADDR_WIDTH = BTB_ADDR_WIDTH,
  parameter int DATA_WIDTH = BTB_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [31:0]           upd_pc,
  input  logic [31:0]           upd_target,
  input  logic                  upd_taken,
  input  logic                  flush_btb,
  output logic                  btb_ce,
  output logic                  btb_we,
  output logic [DATA_WIDTH-1:0] btb_wmask,
  output logic [ADDR_WIDTH-1:0] btb_waddr,
  output logic [DATA_WIDTH-1:0] btb_din,
  output logic                  init_busy,
  output logic [31:0]           btb_write_count_out
);

  localparam int ENTRY_W = 32 + ADDR_WIDTH + 2;

  btb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  ce_q, ce_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  busy_q, busy_d;
  logic [31:0]           cnt_q, cnt_d;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;
  logic               accept_s;
  logic [ENTRY_W-1:0] in_entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic               unused_pc_bits_s;

  assign upd_ready  = !fifo_full_s && !flush_btb && reset_n;
  assign accept_s   = upd_valid && upd_ready && upd_taken;
  assign in_entry_s = {upd_target, upd_pc[PC_IDX_MSB:PC_SLOT_LSB]};
  // With an empty queue in RUN the incoming update bypasses storage.
  assign wr_entry_s = fifo_empty_s ? in_entry_s : head_s;

  assign unused_pc_bits_s = ^{upd_pc[31:PC_IDX_MSB+1], upd_pc[PC_SLOT_LSB-1:0]};

  btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (flush_btb),
    .push_i  (push_s),
    .data_i  (in_entry_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // FSM next state, queue control and next registered write.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ce_d    = 1'b0;
    we_d    = 1'b0;
    wmask_d = '0;
    waddr_d = '0;
    din_d   = '0;
    busy_d  = (state_q == ST_INIT);
    cnt_d   = cnt_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    if (flush_btb) begin
      state_d = ST_INIT;
      sweep_d = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          push_s  = accept_s;
          ce_d    = 1'b1;
          we_d    = 1'b1;
          waddr_d = sweep_q;
          wmask_d = '1;
          din_d   = '0;
          sweep_d = sweep_q + ADDR_WIDTH'(1);
          if (sweep_q == ADDR_WIDTH'(SETS - 1)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_INIT;
          end
        end
        ST_RUN: begin
          if (!fifo_empty_s || accept_s) begin
            pop_s   = !fifo_empty_s;
            push_s  = accept_s && !fifo_empty_s;
            ce_d    = 1'b1;
            we_d    = 1'b1;
            waddr_d = wr_entry_s[ADDR_WIDTH+1:2];
            wmask_d = slot_mask(wr_entry_s[1:0]);
            din_d   = slot_data(wr_entry_s[1:0], wr_entry_s[ENTRY_W-1 -: 32]);
            cnt_d   = cnt_q + 32'd1;
          end else begin
            ce_d = 1'b0;
            we_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_INIT;
          sweep_d = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  // State and registered BTB write port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      waddr_q <= '0;
      din_q   <= '0;
      busy_q  <= 1'b1;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btb_ce              = ce_q;
  assign btb_we              = we_q;
  assign btb_wmask           = wmask_q;
  assign btb_waddr           = waddr_q;
  assign btb_din             = din_q;
  assign init_busy           = busy_q;
  assign btb_write_count_out = cnt_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl: sweep, single writes,
// not-taken handling, flush, full-queue back-pressure and mid-sweep reset.
module tb_btb_update_ctrl;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         upd_valid;
  logic         upd_ready;
  logic [31:0]  upd_pc;
  logic [31:0]  upd_target;
  logic         upd_taken;
  logic         flush_btb;
  logic         btb_ce;
  logic         btb_we;
  logic [128:0] btb_wmask;
  logic [8:0]   btb_waddr;
  logic [128:0] btb_din;
  logic         init_busy;
  logic [31:0]  btb_write_count_out;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  btb_update_ctrl dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .upd_valid           (upd_valid),
    .upd_ready           (upd_ready),
    .upd_pc              (upd_pc),
    .upd_target          (upd_target),
    .upd_taken           (upd_taken),
    .flush_btb           (flush_btb),
    .btb_ce              (btb_ce),
    .btb_we              (btb_we),
    .btb_wmask           (btb_wmask),
    .btb_waddr           (btb_waddr),
    .btb_din             (btb_din),
    .init_busy           (init_busy),
    .btb_write_count_out (btb_write_count_out)
  );

  function automatic logic [128:0] exp_mask(input logic [31:0] pc);
    logic [128:0] m;
    m = 129'(32'hFFFF_FFFF) << (32 * int'(pc[3:2]));
    m[128] = 1'b1;
    return m;
  endfunction

  function automatic logic [128:0] exp_din(input logic [31:0] pc, input logic [31:0] tgt);
    logic [128:0] d;
    d = 129'(tgt) << (32 * int'(pc[3:2]));
    d[128] = 1'b1;
    return d;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; upd_valid = 1'b0; upd_pc = 32'd0; upd_target = 32'd0;
    upd_taken = 1'b0; flush_btb = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (btb_ce !== 1'b0 || btb_we !== 1'b0) begin
      n_fails++; $display("FAIL reset_ce_we: got ce=%b we=%b expected 0 0", btb_ce, btb_we);
    end
    n_checks++;
    if (btb_wmask !== 129'd0 || btb_din !== 129'd0 || btb_waddr !== 9'd0) begin
      n_fails++; $display("FAIL reset_port: got waddr=%h wmask=%h din=%h expected all zero", btb_waddr, btb_wmask, btb_din);
    end
    n_checks++;
    if (init_busy !== 1'b1 || upd_ready !== 1'b0) begin
      n_fails++; $display("FAIL reset_busy_ready: got busy=%b ready=%b expected 1 0", init_busy, upd_ready);
    end
    n_checks++;
    if (btb_write_count_out !== 32'd0) begin
      n_fails++; $display("FAIL reset_count: got %0d expected 0", btb_write_count_out);
    end
  endtask

  task automatic test_init_sweep;
    reset_n = 1'b1;
    for (int i = 0; i < 512; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (btb_waddr !== 9'(i) || btb_ce !== 1'b1 || btb_we !== 1'b1 || btb_wmask !== {129{1'b1}} ||
          btb_din !== 129'd0 || init_busy !== 1'b1) begin
        n_fails++;
        $display("FAIL init_sweep[%0d]: got waddr=%0d ce=%b we=%b busy=%b mask_ones=%b din_zero=%b expected waddr=%0d ce=1 we=1 busy=1 mask_ones=1 din_zero=1",
                 i, btb_waddr, btb_ce, btb_we, init_busy, (btb_wmask === {129{1'b1}}), (btb_din === 129'd0), i);
      end
    end
    @(posedge clock); #1;
    n_checks++;
    if (init_busy !== 1'b0 || btb_ce !== 1'b0) begin
      n_fails++; $display("FAIL init_done: got busy=%b ce=%b expected 0 0", init_busy, btb_ce);
    end
    n_checks++;
    if (upd_ready !== 1'b1 || btb_write_count_out !== 32'd0) begin
      n_fails++; $display("FAIL init_done_ready: got ready=%b count=%0d expected 1 0", upd_ready, btb_write_count_out);
    end
  endtask

  task automatic test_single_write;
    upd_valid = 1'b1; upd_pc = 32'h0000_1238; upd_target = 32'h8000_0040; upd_taken = 1'b1;
    #1;
    n_checks++;
    if (upd_ready !== 1'b1) begin
      n_fails++; $display("FAIL single_ready: got %b expected 1", upd_ready);
    end
    @(posedge clock); #1;
    upd_valid = 1'b0;
    n_checks++;
    if (btb_ce !== 1'b1 || btb_we !== 1'b1 || btb_waddr !== 9'h123) begin
      n_fails++; $display("FAIL single_addr: got ce=%b we=%b waddr=%h expected 1 1 123", btb_ce, btb_we, btb_waddr);
    end
    n_checks++;
    if (btb_wmask !== {1'b1, 32'h0, 32'hFFFF_FFFF, 64'h0}) begin
      n_fails++; $display("FAIL single_wmask: got %h expected %h", btb_wmask, {1'b1, 32'h0, 32'hFFFF_FFFF, 64'h0});
    end
    n_checks++;
    if (btb_din !== {1'b1, 32'h0, 32'h8000_0040, 64'h0}) begin
      n_fails++; $display("FAIL single_din: got %h expected %h", btb_din, {1'b1, 32'h0, 32'h8000_0040, 64'h0});
    end
    n_checks++;
    if (btb_write_count_out !== 32'd1) begin
      n_fails++; $display("FAIL single_count: got %0d expected 1", btb_write_count_out);
    end
    @(posedge clock); #1;
    n_checks++;
    if (btb_ce !== 1'b0 || btb_we !== 1'b0) begin
      n_fails++; $display("FAIL single_idle: got ce=%b we=%b expected 0 0", btb_ce, btb_we);
    end
  endtask

  task automatic test_not_taken;
    upd_valid = 1'b1; upd_pc = 32'h0000_0040; upd_target = 32'hDEAD_BEEF; upd_taken = 1'b0;
    #1;
    n_checks++;
    if (upd_ready !== 1'b1) begin
      n_fails++; $display("FAIL nt_ready: got %b expected 1", upd_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      upd_valid = 1'b0;
      n_checks++;
      if (btb_ce !== 1'b0 || btb_write_count_out !== 32'd1) begin
        n_fails++; $display("FAIL nt_nowrite[%0d]: got ce=%b count=%0d expected 0 1", c, btb_ce, btb_write_count_out);
      end
    end
  endtask

  task automatic test_flush;
    flush_btb = 1'b1;
    @(posedge clock); #1;
    flush_btb = 1'b0;
    n_checks++;
    if (init_busy !== 1'b1 || btb_ce !== 1'b0) begin
      n_fails++; $display("FAIL flush1_busy: got busy=%b ce=%b expected 1 0", init_busy, btb_ce);
    end
    upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = 32'h0000_1000; upd_target = 32'h1111_1111;
    @(posedge clock); #1;
    upd_pc = 32'h0000_2004; upd_target = 32'h2222_2222;
    @(posedge clock); #1;
    n_checks++;
    if (btb_ce !== 1'b1 || btb_waddr !== 9'd1 || init_busy !== 1'b1) begin
      n_fails++; $display("FAIL flush_sweep_start: got ce=%b waddr=%0d busy=%b expected 1 1 1", btb_ce, btb_waddr, init_busy);
    end
    flush_btb = 1'b1; upd_pc = 32'h0000_0030; upd_target = 32'h3333_3333;
    #1;
    n_checks++;
    if (upd_ready !== 1'b0) begin
      n_fails++; $display("FAIL flush_ready: got %b expected 0", upd_ready);
    end
    @(posedge clock); #1;
    flush_btb = 1'b0; upd_valid = 1'b0;
    n_checks++;
    if (init_busy !== 1'b1 || btb_ce !== 1'b0) begin
      n_fails++; $display("FAIL flush2_busy: got busy=%b ce=%b expected 1 0", init_busy, btb_ce);
    end
    for (int i = 0; i < 512; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (btb_waddr !== 9'(i) || btb_ce !== 1'b1 || init_busy !== 1'b1 || btb_din !== 129'd0) begin
        n_fails++; $display("FAIL flush_sweep[%0d]: got waddr=%0d ce=%b busy=%b expected waddr=%0d ce=1 busy=1", i, btb_waddr, btb_ce, init_busy, i);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (init_busy !== 1'b0 || btb_ce !== 1'b0 || btb_write_count_out !== 32'd1) begin
        n_fails++; $display("FAIL flush_dropped[%0d]: got busy=%b ce=%b count=%0d expected 0 0 1", c, init_busy, btb_ce, btb_write_count_out);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs  [6];
    logic [31:0] tgts [6];
    int   sent, widx, first_w, last_w;
    logic ready_s;
    pcs[0] = 32'h0000_1000; tgts[0] = 32'hA000_0000;
    pcs[1] = 32'h0000_0014; tgts[1] = 32'hA000_0011;
    pcs[2] = 32'h0000_1FFC; tgts[2] = 32'hA000_0022;
    pcs[3] = 32'h0000_0008; tgts[3] = 32'hA000_0033;
    pcs[4] = 32'h0000_1238; tgts[4] = 32'hCAFE_F00D;
    pcs[5] = 32'hFFFF_E006; tgts[5] = 32'hA000_0055;
    sent = 0; widx = 0; first_w = -1; last_w = -1; ready_s = 1'b0;
    flush_btb = 1'b1;
    @(posedge clock); #1;
    flush_btb = 1'b0;
    for (int cyc = 0; cyc < 700 && !(widx == 6 && sent == 6); cyc++) begin
      if (upd_valid && ready_s) sent++;
      if (btb_ce && !init_busy) begin
        n_checks++;
        if (widx >= 6) begin
          n_fails++; $display("FAIL b2b_extra_write: got write to %h expected none", btb_waddr);
        end else if (btb_waddr !== pcs[widx][12:4] || btb_wmask !== exp_mask(pcs[widx]) ||
                     btb_din !== exp_din(pcs[widx], tgts[widx])) begin
          n_fails++;
          $display("FAIL b2b_write[%0d]: got waddr=%h din=%h expected waddr=%h din=%h",
                   widx, btb_waddr, btb_din, pcs[widx][12:4], exp_din(pcs[widx], tgts[widx]));
        end
        if (first_w < 0) first_w = cyc;
        last_w = cyc;
        widx++;
      end
      if (cyc == 20) begin
        n_checks++;
        if (sent !== 4 || ready_s !== 1'b0) begin
          n_fails++; $display("FAIL b2b_full: got accepted=%0d ready=%b expected 4 0", sent, ready_s);
        end
      end
      if (sent < 6) begin
        upd_valid = 1'b1; upd_taken = 1'b1; upd_pc = pcs[sent]; upd_target = tgts[sent];
      end else begin
        upd_valid = 1'b0;
      end
      #1;
      ready_s = upd_ready;
      @(posedge clock); #1;
    end
    upd_valid = 1'b0;
    n_checks++;
    if (widx !== 6 || sent !== 6) begin
      n_fails++; $display("FAIL b2b_timeout: got writes=%0d accepted=%0d expected 6 6", widx, sent);
    end
    n_checks++;
    if (last_w - first_w !== 5) begin
      n_fails++; $display("FAIL b2b_consecutive: got span=%0d expected 5", last_w - first_w);
    end
    n_checks++;
    if (btb_ce !== 1'b0 || btb_write_count_out !== 32'd7) begin
      n_fails++; $display("FAIL b2b_end: got ce=%b count=%0d expected 0 7", btb_ce, btb_write_count_out);
    end
  endtask

  task automatic test_reset_midsweep;
    logic found;
    found = 1'b0;
    flush_btb = 1'b1;
    @(posedge clock); #1;
    flush_btb = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(posedge clock); #1;
      if (btb_ce && init_busy && btb_waddr == 9'd200) found = 1'b1;
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_fails++; $display("FAIL mid_reach200: got found=%b expected 1", found);
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (btb_ce !== 1'b0 || btb_we !== 1'b0 || btb_waddr !== 9'd0 || btb_wmask !== 129'd0 || btb_din !== 129'd0) begin
      n_fails++; $display("FAIL mid_reset_port: got ce=%b we=%b waddr=%0d expected 0 0 0 with zero mask/din", btb_ce, btb_we, btb_waddr);
    end
    n_checks++;
    if (init_busy !== 1'b1 || upd_ready !== 1'b0 || btb_write_count_out !== 32'd0) begin
      n_fails++; $display("FAIL mid_reset_state: got busy=%b ready=%b count=%0d expected 1 0 0", init_busy, upd_ready, btb_write_count_out);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (btb_ce !== 1'b1 || btb_waddr !== 9'(i) || init_busy !== 1'b1) begin
        n_fails++; $display("FAIL mid_restart[%0d]: got ce=%b waddr=%0d busy=%b expected 1 %0d 1", i, btb_ce, btb_waddr, init_busy, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_single_write();
    test_not_taken();
    test_flush();
    test_back_to_back();
    test_reset_midsweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side controller that sits directly upstream of the 512-set BTB and drives its write port (ce/we/wmask/waddr/din).
- Buffers resolved-branch updates from the backend in a small FIFO.
- Converts each taken branch into a masked single-slot BTB write.
- Performs a full invalidation sweep of all sets after reset and on flush requests.

Parameters:
- FIFO_DEPTH, 4, update queue entries (power of 2, ≥2)
- SETS, 512, BTB sets swept by init (= 2^ADDR_WIDTH)
- ADDR_WIDTH, 9, BTB set index width
- DATA_WIDTH, 129, BTB entry width (1 valid bit + 4×32-bit targets)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- upd_valid  in  1  resolved-branch update offered
- upd_ready  out  1  update accepted when upd_valid && upd_ready
- upd_pc  in  32  PC of resolved branch
- upd_target  in  32  resolved target address
- upd_taken  in  1  branch resolved taken
- flush_btb  in  1  one-cycle request to invalidate entire BTB
- btb_ce  out  1  BTB chip enable
- btb_we  out  1  BTB write enable
- btb_wmask  out  129  per-bit write mask (1 = bit written)
- btb_waddr  out  9  BTB set index
- btb_din  out  129  write data, bit 128 = valid, slot k at [32k+31:32k]
- init_busy  out  1  invalidation sweep in progress
- btb_write_count_out  out  32  count of update writes issued (init writes excluded)

Behaviour:
- All state is reset synchronously when reset_n=0 at a clock edge.
- Reset values:
  - btb_ce=0, btb_we=0, btb_wmask=0, btb_waddr=0, btb_din=0
  - init_busy=1, upd_ready=0
  - btb_write_count_out=0
  - FIFO empty
  - sweep index=0
- Address mapping:
  - set index = upd_pc[12:4]
  - slot = upd_pc[3:2]
  - upd_pc[1:0] ignored
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle, register a write: ce=we=1, waddr=sweep index, wmask=all ones, din=0.
  - Sweep index increments by 1 per cycle.
  - After the write to set SETS-1, move to RUN; init_busy drops in the same cycle that RUN is entered.
  - The first sweep write is visible in the first cycle after reset_n rises; the sweep occupies exactly SETS cycles.
  - The FIFO accepts updates during INIT but does not drain.
- RUN:
  - If the FIFO is non-empty, pop the head and register a write: ce=we=1, waddr=index.
  - wmask = bit 128 plus bits [32·slot+31:32·slot].
  - din = bit 128 set, upd_target placed in the slot field, all other bits 0.
  - Throughput: one write per cycle. If the FIFO is empty, ce=we=0.
- Output timing:
  - All BTB outputs are registered.
  - An accepted update in cycle N produces its write in cycle N+1 at the earliest (FIFO empty, RUN).
- Upstream handshake:
  - upd_ready = FIFO not full && !flush_btb && reset_n.
  - Updates with upd_taken=0 are accepted (handshake completes) but are neither enqueued nor written.
- Full FIFO:
  - upd_ready=0, upd_valid is held upstream, and no update is lost.
  - A simultaneous pop and push when full is not permitted, because ready is computed from the registered full flag.
- Flush:
  - flush_btb=1 clears the FIFO and resets the sweep index to 0.
  - FSM enters INIT and init_busy is 1 from the next cycle.
  - Any in-flight registered write of that cycle still completes.
  - Flush during INIT restarts the sweep at set 0.
  - Flush and upd_valid in the same cycle: flush wins and the update is not accepted (upd_ready=0).
- Write counter:
  - Increments by 1 for every RUN-state write issued.
  - Wraps modulo 2^32.
  - Not cleared by flush, only by reset.
- Duplicate updates to the same set/slot are written in order; the last one wins.

Decomposition:
- Shared BTB package:
  - BTB_SETS, BTB_ADDR_WIDTH, BTB_DATA_WIDTH, BTB_SLOTS=4, BTB_VALID_BIT=128
  - PC index/slot bit positions
  - FSM state encoding (INIT, RUN)
- One sub-module: btb_upd_fifo.
  - Synchronous FIFO of {target[31:0], pc[12:2]}.
  - Pointers carry an extra wrap bit.
  - Outputs full/empty flags.

Test Plan:
- Release reset → init_busy=1 for exactly 512 cycles; btb_waddr sequences 0..511 with wmask all ones and din=0; then init_busy=0 and ce=0.
- After init, taken update pc=0x0000_1238, target=0x8000_0040 → next cycle we=1, waddr=0x123, wmask bits 128 and [95:64] set, din[95:64]=0x8000_0040, din[128]=1; btb_write_count_out=1.
- Hold upd_valid=1 with 6 taken updates during INIT (FIFO_DEPTH=4) → 4 accepted, then upd_ready=0; after init, 4 writes in order on consecutive cycles, then remaining 2 accepted and written.
- Not-taken update pc=0x40 → handshake completes, no BTB write, counter unchanged.
- flush_btb pulsed with 2 queued entries and upd_valid=1 → upd_ready=0 that cycle; FIFO emptied; new 512-cycle sweep from set 0; queued entries never written.
- Reset asserted mid-sweep (set 200) and released → sweep restarts at set 0; counter and all outputs at reset values.
